// File: rtl/ble_phy_pkg.sv
// ============================================================================
// Module   : ble_phy_pkg
// Brief    : Shared types and constants for the BLE PHY frame-control slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ble_phy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HDR  = 2'd2,
        PLD  = 2'd3
    } state_t;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    localparam int SZW_DEFAULT       = 16;
    localparam int WORD_BITS_DEFAULT = 32;

    // First counting phase for a frame; IDLE means both phases are empty.
    function automatic state_t first_phase(input logic hdr_zero, input logic pld_zero);
        if (!hdr_zero) begin
            return HDR;
        end else if (!pld_zero) begin
            return PLD;
        end else begin
            return IDLE;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ble_irq_ctrl.sv
// ============================================================================
// Module   : ble_irq_ctrl
// Brief    : Per-direction status bit, clear edge detect, chain-clear pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ble_irq_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic irq_clear,
    input  logic irq_en,
    output logic irq,
    output logic chain_clr
);

    logic r_clear_q;
    logic r_sts;
    logic r_chain_clr;
    logic w_clr_rise;

    assign w_clr_rise = irq_clear & ~r_clear_q;

    // A completion on the same edge as a clear keeps the status set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clear_q   <= 1'b0;
            r_sts       <= 1'b0;
            r_chain_clr <= 1'b0;
        end else begin
            r_clear_q   <= irq_clear;
            r_chain_clr <= w_clr_rise;
            if (set) begin
                r_sts <= 1'b1;
            end else if (w_clr_rise) begin
                r_sts <= 1'b0;
            end
        end
    end

    assign irq       = r_sts & irq_en;
    assign chain_clr = r_chain_clr;

endmodule

`default_nettype wire

// File: rtl/ble_frame_sequencer.sv
// ============================================================================
// Module   : ble_frame_sequencer
// Brief    : Tx/Rx frame sequencing against the modem bit strobe, with IRQs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ble_frame_sequencer
    import ble_phy_pkg::*;
#(
    parameter int SZW       = SZW_DEFAULT,
    parameter int WORD_BITS = WORD_BITS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           mode,
    input  logic           dma_mode,
    input  logic           tx_irq_en,
    input  logic           rx_irq_en,
    input  logic           tx_irq_clear,
    input  logic           rx_irq_clear,
    input  logic [SZW-1:0] header_size,
    input  logic [SZW-1:0] payload_size,
    input  logic           bit_strobe,
    input  logic           rx_sync_found,
    output logic           busy,
    output logic           hdr_phase,
    output logic           pld_phase,
    output logic [SZW-1:0] bit_cnt,
    output logic           word_strobe,
    output logic           dma_req,
    output logic           tx_irq,
    output logic           rx_irq,
    output logic           chain_clr_tx_irq,
    output logic           chain_clr_rx_irq
);

    localparam int                WCW         = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [WCW-1:0]    C_WORD_LAST = WCW'(WORD_BITS - 1);
    localparam logic [WCW-1:0]    C_WONE      = WCW'(1);
    localparam logic [SZW-1:0]    C_ONE       = SZW'(1);

    state_t         r_state;
    logic           r_enable_q;
    logic           r_m_mode;
    logic [SZW-1:0] r_m_hdr;
    logic [SZW-1:0] r_m_pld;
    logic [SZW-1:0] r_bit_cnt;
    logic [WCW-1:0] r_word_cnt;
    logic           r_word_strobe;
    logic           r_dma_req;

    logic w_start;
    logic w_hdr_last;
    logic w_pld_last;
    logic w_word_done;
    logic w_complete;
    logic w_complete_mode;
    logic w_set_tx;
    logic w_set_rx;

    assign w_start     = enable & ~r_enable_q & (r_state == IDLE);
    assign w_hdr_last  = (r_state == HDR) & bit_strobe & (r_bit_cnt == r_m_hdr - C_ONE);
    assign w_pld_last  = (r_state == PLD) & bit_strobe & (r_bit_cnt == r_m_pld - C_ONE);
    assign w_word_done = (r_word_cnt == C_WORD_LAST) | w_pld_last;

    // Every path into completion; an abort (enable low) overrides all of them.
    assign w_complete =
        (w_start & (mode == MODE_TX) & (header_size == '0) & (payload_size == '0)) |
        (enable & (r_state == SYNC) & rx_sync_found & (r_m_hdr == '0) & (r_m_pld == '0)) |
        (enable & w_hdr_last & (r_m_pld == '0)) |
        (enable & w_pld_last);

    assign w_complete_mode = (r_state == IDLE) ? mode : r_m_mode;
    assign w_set_tx        = w_complete & (w_complete_mode == MODE_TX);
    assign w_set_rx        = w_complete & (w_complete_mode == MODE_RX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_enable_q    <= 1'b0;
            r_m_mode      <= MODE_TX;
            r_m_hdr       <= '0;
            r_m_pld       <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_word_strobe <= 1'b0;
            r_dma_req     <= 1'b0;
        end else begin
            r_enable_q    <= enable;
            r_word_strobe <= 1'b0;
            r_dma_req     <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_m_mode   <= mode;
                    r_m_hdr    <= header_size;
                    r_m_pld    <= payload_size;
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                    r_state    <= (mode == MODE_RX) ? SYNC
                                : first_phase(header_size == '0, payload_size == '0);
                end
            end else if (!enable) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end else if (r_state == SYNC) begin
                if (rx_sync_found) begin
                    r_state <= first_phase(r_m_hdr == '0, r_m_pld == '0);
                end
            end else if (r_state == HDR) begin
                if (bit_strobe) begin
                    if (w_hdr_last) begin
                        r_bit_cnt <= '0;
                        r_state   <= (r_m_pld == '0) ? IDLE : PLD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + C_ONE;
                    end
                end
            end else begin
                if (bit_strobe) begin
                    // A short final word still produces a word strobe.
                    if (w_word_done) begin
                        r_word_strobe <= 1'b1;
                        r_dma_req     <= dma_mode;
                        r_word_cnt    <= '0;
                    end else begin
                        r_word_cnt <= r_word_cnt + C_WONE;
                    end
                    if (w_pld_last) begin
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + C_ONE;
                    end
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign hdr_phase   = (r_state == HDR);
    assign pld_phase   = (r_state == PLD);
    assign bit_cnt     = r_bit_cnt;
    assign word_strobe = r_word_strobe;
    assign dma_req     = r_dma_req;

    ble_irq_ctrl u_tx_irq (
        .clk       (clk),
        .reset     (reset),
        .set       (w_set_tx),
        .irq_clear (tx_irq_clear),
        .irq_en    (tx_irq_en),
        .irq       (tx_irq),
        .chain_clr (chain_clr_tx_irq)
    );

    ble_irq_ctrl u_rx_irq (
        .clk       (clk),
        .reset     (reset),
        .set       (w_set_rx),
        .irq_clear (rx_irq_clear),
        .irq_en    (rx_irq_en),
        .irq       (rx_irq),
        .chain_clr (chain_clr_rx_irq)
    );

endmodule

`default_nettype wire

// File: tb/tb_ble_frame_sequencer.sv
// ============================================================================
// Module   : tb_ble_frame_sequencer
// Brief    : Directed frames checked against a strobe-count frame model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ble_frame_sequencer;

    localparam int SZW       = 16;
    localparam int WORD_BITS = 32;
    localparam int NSIG      = 12;

    localparam int S_BUSY = 0, S_HDR = 1, S_PLD = 2, S_BCNT = 3, S_WS = 4, S_DMA = 5;
    localparam int S_TXI = 6, S_RXI = 7, S_CTX = 8, S_CRX = 9, S_WSCNT = 10, S_CTXCNT = 11;

    logic           clk = 1'b0;
    logic           reset, enable, mode, dma_mode;
    logic           tx_irq_en, rx_irq_en, tx_irq_clear, rx_irq_clear;
    logic [SZW-1:0] header_size, payload_size;
    logic           bit_strobe, rx_sync_found;
    logic           busy, hdr_phase, pld_phase, word_strobe, dma_req;
    logic           tx_irq, rx_irq, chain_clr_tx_irq, chain_clr_rx_irq;
    logic [SZW-1:0] bit_cnt;

    ble_frame_sequencer #(.SZW(SZW), .WORD_BITS(WORD_BITS)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .mode             (mode),
        .dma_mode         (dma_mode),
        .tx_irq_en        (tx_irq_en),
        .rx_irq_en        (rx_irq_en),
        .tx_irq_clear     (tx_irq_clear),
        .rx_irq_clear     (rx_irq_clear),
        .header_size      (header_size),
        .payload_size     (payload_size),
        .bit_strobe       (bit_strobe),
        .rx_sync_found    (rx_sync_found),
        .busy             (busy),
        .hdr_phase        (hdr_phase),
        .pld_phase        (pld_phase),
        .bit_cnt          (bit_cnt),
        .word_strobe      (word_strobe),
        .dma_req          (dma_req),
        .tx_irq           (tx_irq),
        .rx_irq           (rx_irq),
        .chain_clr_tx_irq (chain_clr_tx_irq),
        .chain_clr_rx_irq (chain_clr_rx_irq)
    );

    always #5 clk = ~clk;

    // Frame model: progress is the number of strobes consumed since sync.
    bit m_act, m_sync, m_mode, m_ws, m_dma, m_txs, m_rxs, m_ctx, m_crx;
    bit p_en, p_ctx, p_crx, m_done, m_set_tx, m_set_rx, m_ctx_rise, m_crx_rise;
    int m_k, m_hdr, m_pld;

    always @(posedge clk) begin
        if (!reset) begin
            m_act = 0; m_sync = 0; m_k = 0; m_ws = 0; m_dma = 0;
            m_txs = 0; m_rxs = 0; m_ctx = 0; m_crx = 0;
            p_en = 0; p_ctx = 0; p_crx = 0;
        end else begin
            m_done = 0; m_set_tx = 0; m_set_rx = 0; m_ws = 0;
            if (!m_act) begin
                if (enable && !p_en) begin
                    m_act = 1; m_mode = mode; m_k = 0;
                    m_hdr = int'(header_size); m_pld = int'(payload_size);
                    m_sync = !mode;
                    if (m_sync && (m_hdr + m_pld == 0)) m_done = 1;
                end
            end else if (!enable) begin
                m_act = 0; m_k = 0;
            end else if (!m_sync) begin
                if (rx_sync_found) begin
                    m_sync = 1;
                    if (m_hdr + m_pld == 0) m_done = 1;
                end
            end else if (bit_strobe) begin
                m_k = m_k + 1;
                if (m_k > m_hdr) begin
                    if (((m_k - m_hdr) % WORD_BITS == 0) || (m_k - m_hdr == m_pld)) m_ws = 1;
                end
                if (m_k == m_hdr + m_pld) m_done = 1;
            end
            if (m_done) begin
                m_act = 0; m_k = 0; m_sync = 0;
                if (m_mode) m_set_rx = 1; else m_set_tx = 1;
            end
            m_dma = m_ws && dma_mode;
            m_ctx_rise = tx_irq_clear && !p_ctx;
            m_crx_rise = rx_irq_clear && !p_crx;
            m_ctx = m_ctx_rise;
            m_crx = m_crx_rise;
            m_txs = m_set_tx ? 1'b1 : (m_ctx_rise ? 1'b0 : m_txs);
            m_rxs = m_set_rx ? 1'b1 : (m_crx_rise ? 1'b0 : m_rxs);
            p_en = enable; p_ctx = tx_irq_clear; p_crx = rx_irq_clear;
        end
    end

    // Literal expectations posted by the stimulus, checked at the next falling edge.
    bit lit_en [NSIG];
    int lit_val[NSIG];
    bit cmp_on = 0;
    int n_cmp = 0, n_bad = 0, n_ws = 0, n_ctx = 0;

    function automatic int dut_sig(int s);
        case (s)
            S_BUSY:   return int'(busy);
            S_HDR:    return int'(hdr_phase);
            S_PLD:    return int'(pld_phase);
            S_BCNT:   return int'(bit_cnt);
            S_WS:     return int'(word_strobe);
            S_DMA:    return int'(dma_req);
            S_TXI:    return int'(tx_irq);
            S_RXI:    return int'(rx_irq);
            S_CTX:    return int'(chain_clr_tx_irq);
            S_CRX:    return int'(chain_clr_rx_irq);
            S_WSCNT:  return n_ws;
            default:  return n_ctx;
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            if (word_strobe) n_ws++;
            if (chain_clr_tx_irq) n_ctx++;
            chk("busy", int'(busy), int'(m_act));
            chk("hdr_phase", int'(hdr_phase), int'(m_act && m_sync && m_k < m_hdr));
            chk("pld_phase", int'(pld_phase), int'(m_act && m_sync && m_k >= m_hdr));
            chk("bit_cnt", int'(bit_cnt),
                (m_act && m_sync) ? ((m_k < m_hdr) ? m_k : m_k - m_hdr) : 0);
            chk("word_strobe", int'(word_strobe), int'(m_ws));
            chk("dma_req", int'(dma_req), int'(m_dma));
            chk("tx_irq", int'(tx_irq), int'(m_txs && tx_irq_en));
            chk("rx_irq", int'(rx_irq), int'(m_rxs && rx_irq_en));
            chk("chain_clr_tx", int'(chain_clr_tx_irq), int'(m_ctx));
            chk("chain_clr_rx", int'(chain_clr_rx_irq), int'(m_crx));
            for (int s = 0; s < NSIG; s++) begin
                if (lit_en[s]) chk($sformatf("literal_sig%0d", s), dut_sig(s), lit_val[s]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        for (int s = 0; s < NSIG; s++) lit_en[s] = 1'b0;
        #1;
    endtask

    task automatic expect_lit(int s, int v);
        lit_en[s]  = 1'b1;
        lit_val[s] = v;
    endtask

    task automatic strobes(int n, int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) tick();
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
        end
    endtask

    task automatic clear_tx();
        tx_irq_clear = 1'b1;
        tick();
        tick();
        tick();
        tx_irq_clear = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < NSIG; s++) begin lit_en[s] = 1'b0; lit_val[s] = 0; end
        reset = 1'b0; enable = 1'b0; mode = 1'b0; dma_mode = 1'b1;
        tx_irq_en = 1'b1; rx_irq_en = 1'b1; tx_irq_clear = 1'b0; rx_irq_clear = 1'b0;
        header_size = '0; payload_size = '0; bit_strobe = 1'b0; rx_sync_found = 1'b0;
        tick();
        cmp_on = 1;
        tick();
        expect_lit(S_BUSY, 0); expect_lit(S_BCNT, 0); expect_lit(S_TXI, 0);
        reset = 1'b1;
        tick();

        // Tx frame: 8 header bits, 64 payload bits, strobe every 4 cycles.
        header_size = 16'd8; payload_size = 16'd64; enable = 1'b1;
        tick();
        expect_lit(S_BUSY, 1); expect_lit(S_HDR, 1); expect_lit(S_BCNT, 0);
        strobes(8, 4);
        expect_lit(S_PLD, 1); expect_lit(S_BCNT, 0);
        strobes(64, 4);
        expect_lit(S_BUSY, 0); expect_lit(S_TXI, 1); expect_lit(S_RXI, 0);
        expect_lit(S_WS, 1); expect_lit(S_DMA, 1); expect_lit(S_WSCNT, 2);
        enable = 1'b0;
        tick();
        tx_irq_clear = 1'b1;
        tick();
        expect_lit(S_CTX, 1); expect_lit(S_TXI, 0);
        tick();
        expect_lit(S_CTX, 0);
        tick();
        tx_irq_clear = 1'b0;
        tick();
        expect_lit(S_CTXCNT, 1);

        // Rx frame: strobes before sync are ignored; clear coincides with completion.
        mode = 1'b1; header_size = 16'd16; payload_size = 16'd40; dma_mode = 1'b0;
        enable = 1'b1;
        tick();
        expect_lit(S_BUSY, 1); expect_lit(S_HDR, 0);
        strobes(3, 2);
        expect_lit(S_BCNT, 0); expect_lit(S_HDR, 0); expect_lit(S_BUSY, 1);
        rx_sync_found = 1'b1;
        tick();
        rx_sync_found = 1'b0;
        expect_lit(S_HDR, 1); expect_lit(S_BCNT, 0);
        strobes(16, 1);
        expect_lit(S_PLD, 1);
        strobes(32, 1);
        expect_lit(S_WS, 1); expect_lit(S_DMA, 0); expect_lit(S_BCNT, 32);
        strobes(7, 1);
        rx_irq_clear = 1'b1;
        strobes(1, 1);
        expect_lit(S_BUSY, 0); expect_lit(S_RXI, 1); expect_lit(S_CRX, 1);
        expect_lit(S_WS, 1); expect_lit(S_WSCNT, 4);
        rx_irq_clear = 1'b0; enable = 1'b0;
        tick();
        rx_irq_clear = 1'b1;
        tick();
        expect_lit(S_RXI, 0);
        rx_irq_clear = 1'b0;
        tick();

        // Zero sizes complete on the start edge; header 0 goes straight to payload.
        mode = 1'b0; dma_mode = 1'b1; header_size = '0; payload_size = '0;
        enable = 1'b1;
        tick();
        expect_lit(S_BUSY, 0); expect_lit(S_TXI, 1);
        enable = 1'b0;
        tick();
        clear_tx();
        payload_size = 16'd5; enable = 1'b1;
        tick();
        expect_lit(S_PLD, 1); expect_lit(S_BUSY, 1);
        strobes(5, 1);
        expect_lit(S_WS, 1); expect_lit(S_TXI, 1); expect_lit(S_BUSY, 0); expect_lit(S_WSCNT, 5);
        enable = 1'b0;
        tick();
        clear_tx();

        // Abort at payload bit 10, then a fresh frame on the next rise.
        header_size = 16'd4; payload_size = 16'd20; enable = 1'b1;
        tick();
        strobes(14, 1);
        expect_lit(S_BCNT, 10); expect_lit(S_PLD, 1);
        enable = 1'b0;
        tick();
        expect_lit(S_BUSY, 0); expect_lit(S_BCNT, 0); expect_lit(S_TXI, 0);
        enable = 1'b1;
        tick();
        expect_lit(S_BUSY, 1); expect_lit(S_HDR, 1); expect_lit(S_BCNT, 0);
        strobes(24, 1);
        expect_lit(S_TXI, 1); expect_lit(S_WSCNT, 6);
        enable = 1'b0;
        tick();

        // Reset mid-header wipes status and frame; a later rise starts normally.
        header_size = 16'd8; payload_size = 16'd8; enable = 1'b1;
        tick();
        strobes(3, 1);
        expect_lit(S_BCNT, 3);
        reset = 1'b0; enable = 1'b0;
        tick();
        expect_lit(S_BUSY, 0); expect_lit(S_BCNT, 0); expect_lit(S_HDR, 0); expect_lit(S_TXI, 0);
        reset = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        expect_lit(S_BUSY, 1); expect_lit(S_HDR, 1);
        strobes(16, 1);
        expect_lit(S_TXI, 1); expect_lit(S_WSCNT, 7);
        enable = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
